// File: rtl/grid_io_bank.sv
// Periphery GPIO tile with a serial config chain, frame counter and load FSM.
// Optional macro GRID_IO_SHADOW_EN adds a shadow register so pads only see complete frames.
module grid_io_bank #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_done,
  input  logic [NUM_IO-1:0] fabric_outpad,
  output logic [NUM_IO-1:0] fabric_inpad,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_A,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_OE,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_IE,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_Y
);

  localparam int CFG_BITS = 2 * NUM_IO;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CFG_BITS-1:0]   shift_q, shift_d;
  logic                  cfg_done_q, cfg_done_d;
  logic [CFG_BITS-1:0]   act_q;

  always_comb begin
    shift_d    = shift_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_done_d = cfg_done_q;
    if (ccff_en) begin
      shift_d = {shift_q[CFG_BITS-2:0], ccff_head};
      case (state_q)
        IDLE, DONE: begin
          state_d    = LOAD;
          cnt_d      = CNT_ONE;
          cfg_done_d = 1'b0;
        end
        LOAD: begin
          cnt_d = cnt_q + 1'b1;
          // The last bit of the frame completes it on this same edge.
          if (cnt_q == CNT_LAST) begin
            state_d    = DONE;
            cfg_done_d = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          cfg_done_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef GRID_IO_SHADOW_EN
  logic [CFG_BITS-1:0] act_shadow_q, act_shadow_d;

  always_comb begin
    act_shadow_d = act_shadow_q;
    if (state_q == LOAD && state_d == DONE) act_shadow_d = shift_d;
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) act_shadow_q <= '0;
    else               act_shadow_q <= act_shadow_d;
  end

  assign act_q = act_shadow_q;
`else
  // Without the shadow, pad controls track the chain directly.
  assign act_q = shift_q;
`endif

  always_comb begin
    for (int i = 0; i < NUM_IO; i++) begin
      gfpga_pad_GPIO_OE[i] = act_q[2*i];
      gfpga_pad_GPIO_IE[i] = act_q[2*i+1];
      fabric_inpad[i]      = act_q[2*i+1] ? gfpga_pad_GPIO_Y[i] : 1'b0;
    end
  end

  assign gfpga_pad_GPIO_A = fabric_outpad;
  assign ccff_tail        = shift_q[CFG_BITS-1];
  assign cfg_done         = cfg_done_q;

endmodule

// File: doc/grid_io_bank.md
# grid_io_bank

Parametrised I/O grid tile for the FPGA fabric periphery: `NUM_IO` GPIO channels driven by one configuration-chain segment. Extends the single-pad I/O tile with per-channel direction and input-enable configuration, a bit counter, a load state machine and double-buffered configuration. Sits on a fabric edge between the routing channels (`*_pin_*` side) and the GPIO pads (`gfpga_pad_*` side), chained through `ccff_head`/`ccff_tail` like every other tile.

## Interface
- `NUM_IO`, default 4: number of GPIO channels, 1..32.
- `CFG_BITS`, derived, `2*NUM_IO`: chain length. Not overridable.
- `CNT_W`, derived, `$clog2(CFG_BITS+1)`: bit-counter width.

- `prog_clk` input 1: the only clock. Drives the chain, counter, FSM and shadow registers.
- `prog_reset_n` input 1: synchronous, active-low reset sampled on `prog_clk` rising edge.
- `ccff_en` input 1: shift enable for the configuration chain.
- `ccff_head` input 1: serial configuration data in.
- `ccff_tail` output 1: serial configuration data out, registered.
- `cfg_done` output 1: high while a complete, applied configuration is held.
- `fabric_outpad` input NUM_IO: fabric-to-pad data.
- `fabric_inpad` output NUM_IO: pad-to-fabric data.
- `gfpga_pad_GPIO_A` output NUM_IO: pad output data.
- `gfpga_pad_GPIO_OE` output NUM_IO: pad output enable.
- `gfpga_pad_GPIO_IE` output NUM_IO: pad input enable.
- `gfpga_pad_GPIO_Y` inout NUM_IO: pad input data. This block only reads it and never drives it.

## Operation
- Chain: `shift_q[CFG_BITS-1:0]`. On a clock edge with `ccff_en=1`, `shift_q <= {shift_q[CFG_BITS-2:0], ccff_head}`. `ccff_tail = shift_q[CFG_BITS-1]`.
- Bit map of the active config `act_q`, per channel i: bit `2i` = OE, bit `2i+1` = IE. The first bit shifted in ends at index `CFG_BITS-1`, so it lands in the IE bit of channel NUM_IO-1.
- Datapath (combinational from `act_q`):
  - `gfpga_pad_GPIO_A[i] = fabric_outpad[i]`
  - `gfpga_pad_GPIO_OE[i] = act_q[2i]`
  - `gfpga_pad_GPIO_IE[i] = act_q[2i+1]`
  - `fabric_inpad[i] = act_q[2i+1] ? gfpga_pad_GPIO_Y[i] : 1'b0`
- FSM states:
  - IDLE: after reset, no shift yet.
  - LOAD: shifting in progress.
  - DONE: full frame applied.
- FSM transitions:
  - IDLE→LOAD on `ccff_en`. `cnt` becomes 1.
  - In LOAD, each `ccff_en` increments `cnt`. On the edge where `cnt` becomes `CFG_BITS`: go to DONE, `act_q <= next shift_q` (same edge), `cfg_done <= 1`.
  - In LOAD, `ccff_en=0` holds state and count.
  - DONE→LOAD on `ccff_en`. `cnt` becomes 1, `cfg_done <= 0`. `act_q` is retained until the next full frame completes.
- Counter never exceeds `CFG_BITS`. There is no wrap-around except via DONE→LOAD.
- Reset (`prog_reset_n=0` at an edge): `shift_q`, `act_q` and `cnt` are cleared, state goes to IDLE, `cfg_done` goes to 0. Reset overrides a simultaneous `ccff_en`. A reset mid-LOAD discards the partial frame.

## Timing
- Reset values:
  - `ccff_tail=0`, `cfg_done=0`.
  - All `gfpga_pad_GPIO_OE`/`IE` = 0.
  - `fabric_inpad` = 0.
  - `gfpga_pad_GPIO_A` follows `fabric_outpad`.
- Chain latency: a bit on `ccff_head` appears on `ccff_tail` after `CFG_BITS` enabled edges.
- `cfg_done` and the new `act_q` become visible together, 0 cycles after the `CFG_BITS`-th enabled edge (registered outputs of that edge).
- `cfg_done` falls on the first enabled edge after DONE.
- Pad/fabric datapath: combinational, zero latency.

## Configuration
- `GRID_IO_SHADOW_EN` defined:
  - `act_q` is a separate shadow register, updated only on frame completion as above.
  - Pads never see partial frames.
- Not defined:
  - `act_q` is an alias of `shift_q`, so pad controls change on every shift.
  - FSM, `cnt` and `cfg_done` behave identically.
  - Saves `CFG_BITS` flops.

## Test plan
- Reset with `ccff_en=1`, `ccff_head=1` → after the edge: `cfg_done=0`, OE=IE=0, `fabric_inpad=0`, state IDLE.
- NUM_IO=4: shift 8 bits `10101010` (first bit first) →
  - after the 8th edge: `cfg_done=1`, `act_q=8'hAA`;
  - IE=4'hF, OE=4'h0;
  - `fabric_inpad` mirrors Y.
- After DONE, shift 3 bits → `cfg_done=0`, outputs unchanged with shadow enabled; outputs change every edge without the macro.
- Partial frame of 5 bits, then `prog_reset_n=0` → `cnt=0`, `act_q=0`, `ccff_tail=0`. A new 8-bit frame then completes with exactly 8 edges.
- Gaps in `ccff_en` mid-frame (toggle every other cycle) → `cfg_done` only on the 8th enabled edge. `ccff_tail` emits the first bit after 8 enabled edges.
- IE=0 on channel 2 with `gfpga_pad_GPIO_Y[2]=1` → `fabric_inpad[2]=0`. `fabric_outpad=4'h5` → `gfpga_pad_GPIO_A=4'h5` regardless of config.
